// File: rtl/word_serializer_mux.sv
// word_serializer_mux: takes a WIDTH-bit word over a valid/ready handshake
// and shifts it out one bit per accepted output beat. The registered select
// index drives an internal binary mux tree and is exported so a downstream
// mux tree can follow the same index.
module word_serializer_mux #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_bit,
  output logic [$clog2(WIDTH)-1:0] out_sel,
  output logic                     out_last,
  output logic                     busy
);

  localparam int SEL_W = $clog2(WIDTH);
  // Leaf count of the mux tree; padding leaves above WIDTH are tied low.
  localparam int LEAVES = 1 << SEL_W;

  localparam logic [SEL_W-1:0] START_IDX = MSB_FIRST ? SEL_W'(WIDTH - 1) : '0;
  localparam logic [SEL_W-1:0] END_IDX   = MSB_FIRST ? '0 : SEL_W'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   word_q, word_d;
  logic [SEL_W-1:0]   sel_q, sel_d;

  logic               sending;
  logic               at_end;
  logic               beat;
  logic               take;
  logic [LEAVES-1:0]  leaves;
  logic               tree_bit;

  assign sending = (state_q == SEND);
  assign at_end  = (sel_q == END_IDX);

  // A beat moves one bit downstream; a take loads a new word. On the last
  // beat in_ready goes high so the next word can load on the same edge.
  assign beat     = sending && out_ready;
  assign in_ready = (state_q == IDLE) || (sending && at_end && out_ready);
  assign take     = in_valid && in_ready;

  assign out_valid = sending;
  assign busy      = sending;
  assign out_last  = sending && at_end;
  assign out_sel   = sel_q;
  // Masked in IDLE so the serial lane idles low regardless of the held word.
  assign out_bit   = sending && tree_bit;

  assign leaves = LEAVES'(word_q);

  // Binary tree of 2:1 muxes. Level l halves the candidates using select bit
  // l, so the root carries word_q[sel_q]. Only registers feed the tree.
  for (genvar lvl = 0; lvl < SEL_W; lvl++) begin : g_lvl
    localparam int NODES = LEAVES >> (lvl + 1);
    logic [NODES-1:0] node;
    for (genvar nd = 0; nd < NODES; nd++) begin : g_node
      if (lvl == 0) begin : g_leaf
        assign node[nd] = sel_q[0] ? leaves[2*nd+1] : leaves[2*nd];
      end else begin : g_inner
        assign node[nd] = sel_q[lvl] ? g_lvl[lvl-1].node[2*nd+1]
                                     : g_lvl[lvl-1].node[2*nd];
      end
    end
  end

  assign tree_bit = g_lvl[SEL_W-1].node[0];

  // Next-state logic: a take (from IDLE or on the final beat) reloads the
  // word and rewinds the index; otherwise a beat either steps the index
  // toward the end or, on the last bit, drops back to IDLE.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    sel_d   = sel_q;
    if (take) begin
      word_d  = in_data;
      sel_d   = START_IDX;
      state_d = SEND;
    end else if (beat) begin
      if (at_end) begin
        state_d = IDLE;
      end else if (MSB_FIRST) begin
        sel_d = sel_q - SEL_W'(1);
      end else begin
        sel_d = sel_q + SEL_W'(1);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      sel_q   <= START_IDX;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      sel_q   <= sel_d;
    end
  end

endmodule

// File: tb/tb_word_serializer_mux.sv
// Directed bench for word_serializer_mux: one MSB-first and one LSB-first
// instance, each scenario in its own task with inline comparisons.
module tb_word_serializer_mux;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       m_in_valid, m_in_ready, m_out_valid, m_out_ready;
  logic       m_out_bit, m_out_last, m_busy;
  logic [7:0] m_in_data;
  logic [2:0] m_out_sel;

  logic       l_in_valid, l_in_ready, l_out_valid, l_out_ready;
  logic       l_out_bit, l_out_last, l_busy;
  logic [7:0] l_in_data;
  logic [2:0] l_out_sel;

  int checks = 0;
  int passes = 0;

  // Observed status packed as {out_valid, busy, out_bit, out_last, in_ready, out_sel}.
  logic [7:0] obs;
  logic [7:0] exp;

  word_serializer_mux #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n),
    .in_valid(m_in_valid), .in_ready(m_in_ready), .in_data(m_in_data),
    .out_valid(m_out_valid), .out_ready(m_out_ready), .out_bit(m_out_bit),
    .out_sel(m_out_sel), .out_last(m_out_last), .busy(m_busy)
  );

  word_serializer_mux #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n),
    .in_valid(l_in_valid), .in_ready(l_in_ready), .in_data(l_in_data),
    .out_valid(l_out_valid), .out_ready(l_out_ready), .out_bit(l_out_bit),
    .out_sel(l_out_sel), .out_last(l_out_last), .busy(l_busy)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    m_in_valid = 1'b1; m_in_data = 8'hFF; m_out_ready = 1'b1;
    l_in_valid = 1'b1; l_in_data = 8'hFF; l_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_in_valid = 1'b0;
    l_in_valid = 1'b0;
    #1;
    obs = {m_out_valid, m_busy, m_out_bit, m_out_last, m_in_ready, m_out_sel};
    exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7};
    checks++;
    if (obs !== exp) $display("[TB] FAIL reset_msb: got %b expected %b", obs, exp);
    else passes++;
    obs = {l_out_valid, l_busy, l_out_bit, l_out_last, l_in_ready, l_out_sel};
    exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0};
    checks++;
    if (obs !== exp) $display("[TB] FAIL reset_lsb: got %b expected %b", obs, exp);
    else passes++;
  endtask

  task automatic test_single_msb();
    logic [7:0] bits;
    bits = 8'b1010_0101;
    @(negedge clk);
    m_in_valid = 1'b1; m_in_data = 8'hA5; m_out_ready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      m_in_valid = 1'b0; m_in_data = 8'h00;
      #1;
      obs = {m_out_valid, m_busy, m_out_bit, m_out_last, m_in_ready, m_out_sel};
      exp = {1'b1, 1'b1, bits[7-b], (b == 7), (b == 7), 3'(7 - b)};
      checks++;
      if (obs !== exp) $display("[TB] FAIL single_beat%0d: got %b expected %b", b, obs, exp);
      else passes++;
    end
    @(negedge clk);
    #1;
    obs = {m_out_valid, m_busy, m_out_bit, m_out_last, m_in_ready, 3'd0};
    exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0};
    checks++;
    if (obs !== exp) $display("[TB] FAIL single_idle: got %b expected %b", obs, exp);
    else passes++;
  endtask

  task automatic test_backpressure();
    logic [7:0]  bits;
    logic [11:0] rdy;
    int          beat_of [12];
    bits = 8'b1010_0101;
    rdy  = 12'b1110_0111_0011;
    beat_of = '{0, 1, 2, 2, 2, 3, 4, 5, 5, 5, 6, 7};
    @(negedge clk);
    m_in_valid = 1'b1; m_in_data = 8'hA5; m_out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      m_in_valid = 1'b0;
      m_out_ready = rdy[c];
      #1;
      obs = {m_out_valid, m_busy, m_out_bit, m_out_last, m_in_ready, m_out_sel};
      exp = {1'b1, 1'b1, bits[7-beat_of[c]], (beat_of[c] == 7),
             (beat_of[c] == 7) && rdy[c], 3'(7 - beat_of[c])};
      checks++;
      if (obs !== exp) $display("[TB] FAIL stall_cycle%0d: got %b expected %b", c, obs, exp);
      else passes++;
    end
    @(negedge clk);
    m_out_ready = 1'b1;
    #1;
    checks++;
    if (m_out_valid !== 1'b0) $display("[TB] FAIL stall_idle: got %b expected 0", m_out_valid);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] bits;
    bits = 16'b0000_1111_1111_0000;
    @(negedge clk);
    m_in_valid = 1'b1; m_in_data = 8'h0F; m_out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      m_in_valid = (c < 8);
      m_in_data = 8'hF0;
      #1;
      obs = {m_out_valid, m_busy, m_out_bit, m_out_last, m_in_ready, m_out_sel};
      exp = {1'b1, 1'b1, bits[15-c], (c == 7 || c == 15), (c == 7 || c == 15),
             3'(7 - (c % 8))};
      checks++;
      if (obs !== exp) $display("[TB] FAIL b2b_beat%0d: got %b expected %b", c, obs, exp);
      else passes++;
    end
    @(negedge clk);
    m_in_valid = 1'b0;
    #1;
    checks++;
    if ({m_out_valid, m_in_ready} !== 2'b01)
      $display("[TB] FAIL b2b_idle: got %b expected 01", {m_out_valid, m_in_ready});
    else passes++;
  endtask

  task automatic test_lsb_first();
    @(negedge clk);
    l_in_valid = 1'b1; l_in_data = 8'h01; l_out_ready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      l_in_valid = 1'b0;
      #1;
      obs = {l_out_valid, l_busy, l_out_bit, l_out_last, l_in_ready, l_out_sel};
      exp = {1'b1, 1'b1, (b == 0), (b == 7), (b == 7), 3'(b)};
      checks++;
      if (obs !== exp) $display("[TB] FAIL lsb_beat%0d: got %b expected %b", b, obs, exp);
      else passes++;
    end
    @(negedge clk);
    #1;
    checks++;
    if (l_out_valid !== 1'b0) $display("[TB] FAIL lsb_idle: got %b expected 0", l_out_valid);
    else passes++;
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] bits;
    bits = 8'b1100_0011;
    @(negedge clk);
    m_in_valid = 1'b1; m_in_data = 8'hC3; m_out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      m_in_valid = 1'b0;
      #1;
      checks++;
      if ({m_out_valid, m_out_bit, m_out_sel} !== {1'b1, bits[7-b], 3'(7 - b)})
        $display("[TB] FAIL midrst_beat%0d: got %b expected %b", b,
                 {m_out_valid, m_out_bit, m_out_sel}, {1'b1, bits[7-b], 3'(7 - b)});
      else passes++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    obs = {m_out_valid, m_busy, m_out_bit, m_out_last, m_in_ready, m_out_sel};
    exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7};
    checks++;
    if (obs !== exp) $display("[TB] FAIL midrst_cleared: got %b expected %b", obs, exp);
    else passes++;
    bits = 8'b1000_0001;
    m_in_valid = 1'b1; m_in_data = 8'h81;
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      m_in_valid = 1'b0;
      #1;
      obs = {m_out_valid, m_busy, m_out_bit, m_out_last, m_in_ready, m_out_sel};
      exp = {1'b1, 1'b1, bits[7-b], (b == 7), (b == 7), 3'(7 - b)};
      checks++;
      if (obs !== exp) $display("[TB] FAIL midrst_new_beat%0d: got %b expected %b", b, obs, exp);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_single_msb();
    test_backpressure();
    test_back_to_back();
    test_lsb_first();
    test_reset_mid_word();
    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
